// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    MULT = 1'b1
  } ctrl_state_t;

  localparam int REG_ZERO            = 0;
  localparam int DEFAULT_MULT_CYCLES = 4;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the EX-stage load and the ID instruction.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             hazard
);

  // Writes to register zero are discarded, so a load into it never creates a dependency.
  assign hazard = ex_mem_read && (ex_rt != REG_W'(REG_ZERO)) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/stall controller: branch/jump squash, load-use stall, multicycle EX
// occupancy, and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int REG_W       = 5,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             id_jump,
  input  logic             id_mult_start,
  output logic             pc_enable,
  output logic             ifid_enable,
  output logic             ifid_flush,
  output logic             idex_enable,
  output logic             idex_flush,
  output logic             exmem_enable,
  output logic             exmem_flush,
  output logic             memwb_enable,
  output logic             memwb_flush,
  output logic             mult_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int CW = $clog2(MULT_CYCLES);

  ctrl_state_t   state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          hazard;

  load_use_detect #(.REG_W(REG_W)) u_load_use (
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .hazard      (hazard)
  );

  // Next-state and pipe-register controls; reset forces every register into flush.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    pc_enable    = 1'b1;
    ifid_enable  = 1'b1;
    ifid_flush   = 1'b0;
    idex_enable  = 1'b1;
    idex_flush   = 1'b0;
    exmem_enable = 1'b1;
    exmem_flush  = 1'b0;
    memwb_enable = 1'b1;
    memwb_flush  = 1'b0;
    mult_busy    = 1'b0;
    if (reset) begin
      state_next   = RUN;
      cnt_next     = {CW{1'b0}};
      pc_enable    = 1'b0;
      ifid_enable  = 1'b0;
      ifid_flush   = 1'b1;
      idex_enable  = 1'b0;
      idex_flush   = 1'b1;
      exmem_enable = 1'b0;
      exmem_flush  = 1'b1;
      memwb_enable = 1'b0;
      memwb_flush  = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (hazard) begin
            pc_enable   = 1'b0;
            ifid_enable = 1'b0;
            idex_flush  = 1'b1;
          end else if (id_mult_start) begin
            state_next = MULT;
            cnt_next   = CW'(MULT_CYCLES - 1);
          end else if (id_jump) begin
            ifid_flush = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
        MULT: begin
          pc_enable   = 1'b0;
          ifid_enable = 1'b0;
          idex_enable = 1'b0;
          exmem_flush = 1'b1;
          mult_busy   = 1'b1;
          cnt_next    = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state_next = RUN;
          end else begin
            state_next = MULT;
          end
        end
        default: begin
          state_next = RUN;
          cnt_next   = {CW{1'b0}};
        end
      endcase
    end
  end

  // State, occupancy counter and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      cnt          <= {CW{1'b0}};
      stall_cycles <= {CNT_W{1'b0}};
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (!pc_enable && (stall_cycles != {CNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cycles <= stall_cycles;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (MULT_CYCLES=4, CNT_W=4).
module tb_pipe_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  // Control vector order: pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_en, memwb_fl, busy
  localparam logic [9:0] C_RST  = 10'b0010101010;
  localparam logic [9:0] C_RUN  = 10'b1101010100;
  localparam logic [9:0] C_LU   = 10'b0001110100;
  localparam logic [9:0] C_BR   = 10'b1111110100;
  localparam logic [9:0] C_JMP  = 10'b1111010100;
  localparam logic [9:0] C_MULT = 10'b0000011101;

  typedef struct {
    string      tag;
    logic [9:0] ctrl;
    logic [CNT_W-1:0] stall;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [REG_W-1:0] id_rs = 5'd0, id_rt = 5'd0, ex_rt = 5'd0;
  logic id_uses_rt = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic id_jump = 1'b0, id_mult_start = 1'b0;
  logic pc_enable, ifid_enable, ifid_flush, idex_enable, idex_flush;
  logic exmem_enable, exmem_flush, memwb_enable, memwb_flush, mult_busy;
  logic [CNT_W-1:0] stall_cycles;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int model_stall = 0;

  pipe_hazard_ctrl #(.MULT_CYCLES(4), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .id_jump(id_jump), .id_mult_start(id_mult_start), .pc_enable(pc_enable),
    .ifid_enable(ifid_enable), .ifid_flush(ifid_flush), .idex_enable(idex_enable),
    .idex_flush(idex_flush), .exmem_enable(exmem_enable), .exmem_flush(exmem_flush),
    .memwb_enable(memwb_enable), .memwb_flush(memwb_flush), .mult_busy(mult_busy),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $fatal(1, "FAIL watchdog: simulation time limit reached");
  end

  // One cycle: drive at negedge, push expectation, sample 1ns later, then advance the stall model.
  task automatic step(input string tag, input logic rst, input logic rd, input logic [4:0] ert,
                      input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic br, input logic jmp, input logic ms, input logic [9:0] ectrl);
    exp_t e;
    logic [9:0] got;
    @(negedge clk);
    reset = rst; ex_mem_read = rd; ex_rt = ert; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    ex_branch_taken = br; id_jump = jmp; id_mult_start = ms;
    sb.push_back('{tag, ectrl, CNT_W'(model_stall)});
    #1;
    e = sb.pop_front();
    got = {pc_enable, ifid_enable, ifid_flush, idex_enable, idex_flush,
           exmem_enable, exmem_flush, memwb_enable, memwb_flush, mult_busy};
    total++;
    assert (got === e.ctrl) else begin
      bad++;
      $error("FAIL %s ctrl: got=%b want=%b", e.tag, got, e.ctrl);
    end
    total++;
    assert (stall_cycles === e.stall) else begin
      bad++;
      $error("FAIL %s stall: got=%0d want=%0d", e.tag, stall_cycles, e.stall);
    end
    if (rst) model_stall = 0;
    else if (!e.ctrl[9] && model_stall < 15) model_stall++;
  endtask

  initial begin
    step("rst0",     1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RST);
    step("rst1",     1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RST);
    step("idle",     1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN);
    step("lu_rs",    1'b0, 1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_LU);
    step("lu_after", 1'b0, 1'b0, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN);
    step("lu_zero",  1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN);
    step("lu_rt",    1'b0, 1'b1, 5'd9, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, C_LU);
    step("rt_unused",1'b0, 1'b1, 5'd9, 5'd2, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN);
    step("br_lu",    1'b0, 1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, C_BR);
    step("jump",     1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, C_JMP);
    step("mstart",   1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, C_RUN);
    step("mult1_br", 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, C_MULT);
    step("mult2_lu", 1'b0, 1'b1, 5'd8, 5'd8, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, C_MULT);
    step("mult3",    1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, C_MULT);
    step("mult_done",1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN);
    step("lu_ms",    1'b0, 1'b1, 5'd7, 5'd7, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, C_LU);
    step("ms_late",  1'b0, 1'b0, 5'd7, 5'd7, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, C_RUN);
    for (int i = 0; i < 3; i++)
      step("mult_b",  1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, C_MULT);
    step("run_b",    1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN);
    step("mstart_c", 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, C_RUN);
    step("mult_c1",  1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, C_MULT);
    step("rst_mult", 1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, C_RST);
    step("post_rst", 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN);
    for (int i = 0; i < 20; i++)
      step("sat_lu",  1'b0, 1'b1, 5'd5, 5'd5, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, C_LU);
    step("sat_end",  1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN);
    total++;
    assert (stall_cycles === 4'd15) else begin
      bad++;
      $error("FAIL sat_final: got=%0d want=15", stall_cycles);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
